// File: rtl/memory_stage.sv
// Y86-64 memory stage: latches one request, performs an 8-byte little-endian access
// against a private byte-addressed data memory after a programmable latency, and
// reports valM/dmem_error with a one-cycle done pulse.
module memory_stage #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        ready,
    output logic        done,
    output logic [63:0] valM,
    output logic        dmem_error
);

    localparam int unsigned MemBytes = 1 << ADDR_W;
    localparam int unsigned CntW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    // Highest legal word address; the compare is full 64-bit so upper bits must be zero.
    localparam logic [63:0] MaxAddr  = 64'((64'd1 << ADDR_W) - 64'd8);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        icode_q;
    logic [63:0]       vale_q, vala_q, valp_q;
    logic [63:0]       valm_q, valm_d;
    logic              err_q, err_d;
    logic [7:0]        mem [MemBytes];

    logic              accept, do_access;
    logic              op_write, op_read, addr_ok, mem_we;
    logic [63:0]       addr, wdata, rdata;
    logic [ADDR_W-1:0] widx;

    function automatic logic is_write_op(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    endfunction

    function automatic logic is_read_op(input logic [3:0] ic);
        return (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    endfunction

    // Decode the latched request: address, write data and range check.
    always_comb begin
        op_write = is_write_op(icode_q);
        op_read  = is_read_op(icode_q);
        addr     = ((icode_q == 4'h9) || (icode_q == 4'hB)) ? vala_q : vale_q;
        wdata    = (icode_q == 4'h8) ? valp_q : vala_q;
        addr_ok  = (addr <= MaxAddr);
        widx     = addr[ADDR_W-1:0];
        rdata    = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[widx + ADDR_W'(i)];
        end
    end

    // FSM next state, latency counter and access strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = StWait;
                    cnt_d   = (is_write_op(icode) || is_read_op(icode)) ?
                              CntW'(MEM_LAT - 1) : '0;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    do_access = 1'b1;
                    state_d   = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result registers only change on the access edge.
    always_comb begin
        valm_d = valm_q;
        err_d  = err_q;
        if (do_access) begin
            valm_d = (op_read && addr_ok) ? rdata : '0;
            err_d  = (op_read || op_write) && !addr_ok;
        end
    end

    assign mem_we = do_access && op_write && addr_ok && !reset;

    // State, counter, latched operands and results; reset wins at every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            icode_q <= '0;
            vale_q  <= '0;
            vala_q  <= '0;
            valp_q  <= '0;
            valm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
            if (accept) begin
                icode_q <= icode;
                vale_q  <= valE;
                vala_q  <= valA;
                valp_q  <= valP;
            end
        end
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                mem[widx + ADDR_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    assign ready      = (state_q == StIdle);
    assign done       = (state_q == StResp);
    assign valM       = valm_q;
    assign dmem_error = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (main instance MEM_LAT=2, plus
// MEM_LAT=1 and MEM_LAT=4 instances for latency checks).
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset, start, start1, start4;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    logic        ready, done, dmem_error;
    logic [63:0] valM;
    logic        ready1, done1, err1, ready4, done4, err4;
    logic [63:0] valm1, valm4;

    int          errors = 0;
    int          checks = 0;
    int          lat;
    logic [63:0] m;
    logic        er;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(10), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .icode(icode), .valE(valE), .valA(valA),
        .valP(valP), .ready(ready), .done(done), .valM(valM), .dmem_error(dmem_error)
    );

    memory_stage #(.ADDR_W(10), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .icode(icode), .valE(valE), .valA(valA),
        .valP(valP), .ready(ready1), .done(done1), .valM(valm1), .dmem_error(err1)
    );

    memory_stage #(.ADDR_W(10), .MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .icode(icode), .valE(valE), .valA(valA),
        .valP(valP), .ready(ready4), .done(done4), .valM(valm4), .dmem_error(err4)
    );

    // Issue one request on the main instance; lat = edges from accept to done (99 = none).
    task automatic do_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                         input logic [63:0] p);
        @(negedge clk);
        icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        m  = valM;
        er = dmem_error;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (valM !== 64'h0) begin errors++; $display("FAIL reset_valM got=%h exp=0", valM); end
        checks++; if (dmem_error !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", dmem_error); end
    endtask

    task automatic test_rw();
        do_op(4'h4, 64'h18, 64'h0, 64'h0);
        do_op(4'h4, 64'h10, 64'h1122334455667788, 64'h0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (m !== 64'h0) begin errors++; $display("FAIL wr_valM got=%h exp=0", m); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
        do_op(4'h5, 64'h10, 64'h0, 64'h0);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++; if (m !== 64'h1122334455667788) begin errors++; $display("FAIL rd_aligned got=%h exp=1122334455667788", m); end
        do_op(4'h5, 64'h11, 64'h0, 64'h0);
        checks++; if (m !== 64'h0011223344556677) begin errors++; $display("FAIL rd_unaligned got=%h exp=0011223344556677", m); end
    endtask

    task automatic test_stack();
        do_op(4'h8, 64'h3F8, 64'h77, 64'h40);
        checks++; if (m !== 64'h0 || er !== 1'b0) begin errors++; $display("FAIL call_result got=%h/%b exp=0/0", m, er); end
        do_op(4'h9, 64'h0, 64'h3F8, 64'h0);
        checks++; if (m !== 64'h40) begin errors++; $display("FAIL ret_valM got=%h exp=40", m); end
        do_op(4'hA, 64'h3F0, 64'hDEADBEEF, 64'h99);
        do_op(4'hB, 64'h0, 64'h3F0, 64'h0);
        checks++; if (m !== 64'hDEADBEEF) begin errors++; $display("FAIL pop_valM got=%h exp=deadbeef", m); end
    endtask

    task automatic test_range();
        do_op(4'h5, 64'h3F8, 64'h0, 64'h0);
        checks++; if (m !== 64'h40 || er !== 1'b0) begin errors++; $display("FAIL rd_top got=%h/%b exp=40/0", m, er); end
        do_op(4'h5, 64'h3F9, 64'h0, 64'h0);
        checks++; if (m !== 64'h0 || er !== 1'b1) begin errors++; $display("FAIL rd_oob got=%h/%b exp=0/1", m, er); end
        do_op(4'h4, 64'hFFFFFFFFFFFFFFF8, 64'h5555, 64'h0);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr_oob_err got=%b exp=1", er); end
        do_op(4'h5, 64'h1_0000_0010, 64'h0, 64'h0);
        checks++; if (m !== 64'h0 || er !== 1'b1) begin errors++; $display("FAIL rd_upper got=%h/%b exp=0/1", m, er); end
        do_op(4'h5, 64'h3F8, 64'h0, 64'h0);
        checks++; if (m !== 64'h40 || er !== 1'b0) begin errors++; $display("FAIL wr_oob_nowrite got=%h/%b exp=40/0", m, er); end
    endtask

    task automatic test_nonmem();
        do_op(4'h6, 64'h10, 64'h55, 64'h66);
        checks++; if (lat !== 1) begin errors++; $display("FAIL opq_latency got=%0d exp=1", lat); end
        checks++; if (m !== 64'h0 || er !== 1'b0) begin errors++; $display("FAIL opq_result got=%h/%b exp=0/0", m, er); end
        do_op(4'h6, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL opq_no_range got=%b exp=0", er); end
        do_op(4'h5, 64'h10, 64'h0, 64'h0);
        checks++; if (m !== 64'h1122334455667788) begin errors++; $display("FAIL opq_nowrite got=%h exp=1122334455667788", m); end
    endtask

    // Start held high through WAIT/RESP and operands changed after accept.
    task automatic test_back_to_back();
        int dcnt = 0;
        int first = 0;
        @(negedge clk);
        icode = 4'h5; valE = 64'h10; valA = 64'h0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        icode = 4'h4; valE = 64'h3F8; valA = 64'h1234;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dcnt++;
                if (first == 0) first = n;
                m = valM;
            end
        end
        start = 1'b0;
        checks++; if (dcnt !== 1 || first !== 2) begin errors++; $display("FAIL b2b_done got=%0d@%0d exp=1@2", dcnt, first); end
        checks++; if (m !== 64'h1122334455667788) begin errors++; $display("FAIL b2b_latched got=%h exp=1122334455667788", m); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", ready); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_not_queued got=%b exp=0", done); end
        do_op(4'h5, 64'h3F8, 64'h0, 64'h0);
        checks++; if (m !== 64'h40) begin errors++; $display("FAIL b2b_nowrite got=%h exp=40", m); end
    endtask

    // Latency on the MEM_LAT=1 and MEM_LAT=4 instances.
    task automatic measure_alt(input bit use4, input logic [3:0] ic, output int l);
        @(negedge clk);
        icode = ic; valE = 64'h0; valA = 64'h0; valP = 64'h0;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        l = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if ((use4 && done4) || (!use4 && done1)) begin
                l = n;
                break;
            end
        end
    endtask

    task automatic test_latency();
        int l;
        measure_alt(1'b0, 4'h5, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL lat1_mem got=%0d exp=1", l); end
        measure_alt(1'b1, 4'h5, l);
        checks++; if (l !== 4) begin errors++; $display("FAIL lat4_mem got=%0d exp=4", l); end
        measure_alt(1'b1, 4'h6, l);
        checks++; if (l !== 1) begin errors++; $display("FAIL lat4_nonmem got=%0d exp=1", l); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        do_op(4'h4, 64'h20, 64'h77, 64'h0);
        // Abort during WAIT (reset at E0+1).
        @(negedge clk);
        icode = 4'h4; valE = 64'h20; valA = 64'hAA; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_wait_ready got=%b exp=1", ready); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        // Abort exactly on the access edge (E0+2).
        @(negedge clk);
        icode = 4'h4; valE = 64'h20; valA = 64'hBB; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        if (done) seen++;
        checks++; if (ready !== 1'b1 || valM !== 64'h0) begin errors++; $display("FAIL abort_access got=%b/%h exp=1/0", ready, valM); end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
        do_op(4'h5, 64'h20, 64'h0, 64'h0);
        checks++; if (m !== 64'h77) begin errors++; $display("FAIL abort_nowrite got=%h exp=77", m); end
        // Reset and start together: request dropped.
        seen = 0;
        @(negedge clk);
        icode = 4'h5; valE = 64'h20; reset = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done || !ready) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_start_drop got=%0d exp=0", seen); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start1 = 1'b0; start4 = 1'b0;
        icode = 4'h0; valE = 64'h0; valA = 64'h0; valP = 64'h0;
        test_reset();
        test_rw();
        test_stack();
        test_range();
        test_nonmem();
        test_back_to_back();
        test_latency();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
